stopwatch_display: RTL

Display back-end fed directly by the stopwatch core's `minutes[7:0]`, `seconds[5:0]` and `status[1:0]` outputs. It converts the binary time to BCD with a serial double-dabble engine and drives a five-digit, time-multiplexed, active-low seven-segment display in the format `MMM.SS`. It blanks leading minute zeros and blinks the whole display while the stopwatch is paused.

---
 rtl/stopwatch_pkg.sv | 43 ++++
 rtl/bcd_converter.sv | 46 ++++
 rtl/stopwatch_display.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch display back-end: status codes,
// active-low seven-segment patterns and the capture FSM encoding.
package stopwatch_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    // Segment order {g,f,e,d,c,b,a}, 0 = lit
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef logic [1:0] disp_state_t;
    localparam disp_state_t S_IDLE   = 2'd0;
    localparam disp_state_t S_SHIFT  = 2'd1;
    localparam disp_state_t S_COMMIT = 2'd2;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bcd_converter.sv
// Serial 8-bit double-dabble: start loads the operand, then eight
// adjust-and-shift cycles leave three BCD nibbles in bcd.
module bcd_converter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic [11:0] bcd,
    output logic        done
);

    logic [19:0] sh_q, sh_d, adj;
    logic [3:0]  cnt_q, cnt_d;

    always_comb begin
        adj = sh_q;
        for (int i = 0; i < 3; i++) begin
            if (sh_q[8+4*i +: 4] >= 4'd5)
                adj[8+4*i +: 4] = sh_q[8+4*i +: 4] + 4'd3;
        end
        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (start) begin
            sh_d  = {12'd0, bin};
            cnt_d = 4'd0;
        end else if (cnt_q != 4'd8) begin
            sh_d  = {adj[18:0], 1'b0};
            cnt_d = cnt_q + 4'd1;
        end
    end

    // cnt_q parks at 8 when no conversion is running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= '0;
            cnt_q <= 4'd8;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

    assign bcd  = sh_q[19:8];
    assign done = (cnt_q == 4'd8);

endmodule

// File: rtl/stopwatch_display.sv
// Five-digit MMM.SS multiplexed seven-segment driver: captures time,
// converts to BCD, scans digits, blanks leading zeros, blinks when paused.
module stopwatch_display
    import stopwatch_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] minutes,
    input  logic [5:0] seconds,
    input  logic [1:0] status,
    output logic [6:0] seg,
    output logic       dp,
    output logic [4:0] an,
    output logic       busy
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_DIV);

    disp_state_t      state_q, state_d;
    logic [2:0]       sh_cnt_q, sh_cnt_d;
    logic [7:0]       cap_min_q, cap_min_d;
    logic [5:0]       cap_sec_q, cap_sec_d;
    logic [4:0][3:0]  dig_q, dig_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [2:0]       idx_q, idx_d;
    logic [BW-1:0]    blk_cnt_q, blk_cnt_d;
    logic             phase_q, phase_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [4:0]       an_q, an_d;
    logic             busy_q, busy_d;

    logic             start;
    logic [11:0]      bcd_m, bcd_s;
    logic             done_m, done_s;
    logic             sec_hund_unused;
    logic [3:0]       cur;
    logic             blank;

    assign start = (state_q == S_IDLE) &&
                   ({minutes, seconds} != {cap_min_q, cap_sec_q});

    bcd_converter u_conv_min (
        .clk(clk), .rst_n(rst_n), .start(start),
        .bin(minutes), .bcd(bcd_m), .done(done_m)
    );

    bcd_converter u_conv_sec (
        .clk(clk), .rst_n(rst_n), .start(start),
        .bin({2'b00, seconds}), .bcd(bcd_s), .done(done_s)
    );

    // Seconds never exceed 63, so their hundreds nibble is always zero
    assign sec_hund_unused = ^bcd_s[11:8];

    always_comb begin
        state_d   = state_q;
        sh_cnt_d  = sh_cnt_q;
        cap_min_d = cap_min_q;
        cap_sec_d = cap_sec_q;
        dig_d     = dig_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cap_min_d = minutes;
                    cap_sec_d = seconds;
                    sh_cnt_d  = 3'd0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sh_cnt_d = sh_cnt_q + 3'd1;
                if (sh_cnt_q == 3'd7) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                if (done_m && done_s)
                    dig_d = {bcd_m[11:8], bcd_m[7:4], bcd_m[3:0],
                             bcd_s[7:4], bcd_s[3:0]};
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pre_d = pre_q;
        idx_d = idx_q;
        if (pre_q == PW'(SCAN_DIV - 1)) begin
            pre_d = '0;
            idx_d = (idx_q == 3'd0) ? 3'd4 : idx_q - 3'd1;
        end else begin
            pre_d = pre_q + 1'b1;
        end

        blk_cnt_d = '0;
        phase_d   = 1'b1;
        if (status == ST_PAUSE) begin
            phase_d = phase_q;
            if (blk_cnt_q == BW'(BLINK_DIV - 1)) begin
                blk_cnt_d = '0;
                phase_d   = ~phase_q;
            end else begin
                blk_cnt_d = blk_cnt_q + 1'b1;
            end
        end
    end

    // Outputs are built from next-state values so they move with their cause
    always_comb begin
        cur   = dig_d[idx_d];
        blank = ((idx_d == 3'd4) && (dig_d[4] == 4'd0)) ||
                ((idx_d == 3'd3) && (dig_d[4] == 4'd0) && (dig_d[3] == 4'd0));
        an_d   = ~(5'b00001 << idx_d);
        seg_d  = blank ? SEG_BLANK : seg_decode(cur);
        dp_d   = (idx_d == 3'd2) ? 1'b0 : 1'b1;
        busy_d = (state_d != S_IDLE);
        if (!phase_d) begin
            an_d  = 5'b11111;
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sh_cnt_q  <= '0;
            cap_min_q <= '0;
            cap_sec_q <= '0;
            dig_q     <= '0;
            pre_q     <= '0;
            idx_q     <= 3'd4;
            blk_cnt_q <= '0;
            phase_q   <= 1'b1;
            seg_q     <= SEG_BLANK;
            dp_q      <= 1'b1;
            an_q      <= 5'b11111;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_cnt_q  <= sh_cnt_d;
            cap_min_q <= cap_min_d;
            cap_sec_q <= cap_sec_d;
            dig_q     <= dig_d;
            pre_q     <= pre_d;
            idx_q     <= idx_d;
            blk_cnt_q <= blk_cnt_d;
            phase_q   <= phase_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            an_q      <= an_d;
            busy_q    <= busy_d;
        end
    end

    assign seg  = seg_q;
    assign dp   = dp_q;
    assign an   = an_q;
    assign busy = busy_q;

endmodule
